hdmi_out_reader: RTL and testbench

HDMI_OUT_READER -- requirements
Module: hdmi_out_reader

---
 rtl/hdmi_out_reader.sv | 170 +++++++++++++++++
 tb/tb_hdmi_out_reader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_out_reader.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_out_reader
// Purpose  : Video timing generator that pops RGB888 pixels from a FIFO and
//            aligns them with DE/HS/VS across the FIFO read latency.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_out_reader #(
    parameter int          H_ACTIVE   = 1280,
    parameter int          H_FP       = 110,
    parameter int          H_SYNC     = 40,
    parameter int          H_BP       = 220,
    parameter int          V_ACTIVE   = 720,
    parameter int          V_FP       = 5,
    parameter int          V_SYNC     = 5,
    parameter int          V_BP       = 20,
    parameter bit          SYNC_POL   = 1'b1,
    parameter int          RD_LATENCY = 2,
    parameter logic [23:0] FILL_COLOR = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        fifo_rd_en,
    input  logic [23:0] fifo_rd_data,
    input  logic        fifo_rd_empty,
    output logic        vid_hs,
    output logic        vid_vs,
    output logic        vid_de,
    output logic [23:0] vid_data,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] c_h_last = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] c_h_act  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] c_hs_beg = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] c_hs_end = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] c_v_last = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] c_v_act  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] c_vs_beg = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] c_vs_end = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          c_sync_idle = ~SYNC_POL;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic miss;
    } tap_t;

    state_t        state_q;
    logic [HW-1:0] h_cnt_q;
    logic [VW-1:0] v_cnt_q;

    logic          w_run;
    tap_t          stage0_d;
    tap_t          pipe_q [RD_LATENCY];
    tap_t          w_tap;

    logic          vid_de_q;
    logic          vid_hs_q;
    logic          vid_vs_q;
    logic [23:0]   vid_data_q;
    logic [23:0]   vid_data_d;
    logic          underflow_q;
    logic          underflow_d;

    // Stage 0: raw timing decoded straight from the registered counters.
    assign w_run         = (state_q == S_RUN);
    assign stage0_d.de   = w_run && (h_cnt_q < c_h_act) && (v_cnt_q < c_v_act);
    assign stage0_d.hs   = w_run && (h_cnt_q >= c_hs_beg) && (h_cnt_q < c_hs_end);
    assign stage0_d.vs   = w_run && (v_cnt_q >= c_vs_beg) && (v_cnt_q < c_vs_end);
    assign stage0_d.miss = stage0_d.de && fifo_rd_empty;

    assign fifo_rd_en  = stage0_d.de && !fifo_rd_empty;
    assign frame_start = w_run && (h_cnt_q == '0) && (v_cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (en) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (!en)                 state_q <= S_IDLE;
                    else if (!fifo_rd_empty) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (h_cnt_q == c_h_last) begin
                        h_cnt_q <= '0;
                        if (v_cnt_q == c_v_last) begin
                            // en is only honoured at the frame boundary.
                            v_cnt_q <= '0;
                            if (!en) state_q <= S_IDLE;
                        end else begin
                            v_cnt_q <= v_cnt_q + 1'b1;
                        end
                    end else begin
                        h_cnt_q <= h_cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Delay line matching the FIFO read latency so the tap meets fifo_rd_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= stage0_d;
            for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign w_tap = pipe_q[RD_LATENCY-1];

    always_comb begin
        vid_data_d = 24'h000000;
        if (w_tap.de) vid_data_d = w_tap.miss ? FILL_COLOR : fifo_rd_data;
    end

    assign underflow_d = (underflow_q && !underflow_clr) || (w_tap.de && w_tap.miss);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_de_q    <= 1'b0;
            vid_hs_q    <= c_sync_idle;
            vid_vs_q    <= c_sync_idle;
            vid_data_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            vid_de_q    <= w_tap.de;
            vid_hs_q    <= w_tap.hs ^ c_sync_idle;
            vid_vs_q    <= w_tap.vs ^ c_sync_idle;
            vid_data_q  <= vid_data_d;
            underflow_q <= underflow_d;
        end
    end

    assign vid_de    = vid_de_q;
    assign vid_hs    = vid_hs_q;
    assign vid_vs    = vid_vs_q;
    assign vid_data  = vid_data_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_out_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_out_reader
// Purpose  : Randomised self-checking bench for hdmi_out_reader using a small
//            frame-position reference model and a behavioural pixel FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_out_reader;

    localparam int          c_h_act  = 4;
    localparam int          c_h_tot  = 8;
    localparam int          c_v_act  = 2;
    localparam int          c_frame  = 40;
    localparam logic [23:0] c_fill   = 24'hA55AC3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        underflow_clr = 1'b0;
    logic        fifo_rd_en, fifo_rd_empty;
    logic [23:0] fifo_rd_data;
    logic        vid_hs, vid_vs, vid_de, frame_start, underflow;
    logic [23:0] vid_data;
    logic        n_fifo_rd_en, n_vid_hs, n_vid_vs, n_vid_de, n_frame_start, n_underflow;
    logic [23:0] n_vid_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hdmi_out_reader #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .RD_LATENCY(2), .FILL_COLOR(c_fill)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data),
        .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr)
    );

    hdmi_out_reader #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .RD_LATENCY(2), .FILL_COLOR(c_fill)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .en(en),
        .fifo_rd_en(n_fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .vid_hs(n_vid_hs), .vid_vs(n_vid_vs), .vid_de(n_vid_de), .vid_data(n_vid_data),
        .frame_start(n_frame_start), .underflow(n_underflow), .underflow_clr(underflow_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural pixel FIFO with a two-clock read latency.
    logic [23:0] mem [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        wr_req = 1'b0;
    logic [23:0] wr_val = '0;
    logic [23:0] rd_pipe1 = '0;
    logic [23:0] rd_pipe2 = '0;

    assign fifo_rd_empty = (wr_ptr == rd_ptr);
    assign fifo_rd_data  = rd_pipe2;

    always @(posedge clk) begin
        if (wr_req) begin
            mem[wr_ptr % 256] <= wr_val;
            wr_ptr            <= wr_ptr + 1;
        end
        if (fifo_rd_en && !fifo_rd_empty) begin
            rd_pipe1 <= mem[rd_ptr % 256];
            rd_ptr   <= rd_ptr + 1;
        end
        rd_pipe2 <= rd_pipe1;
    end

    // Reference model: mode 0 idle, 1 waiting, 2 running; pos = clock within frame.
    int          m_mode = 0;
    int          m_pos  = 0;
    logic        m_uf   = 1'b0;
    logic        hist_de [3];
    logic        hist_hs [3];
    logic        hist_vs [3];
    logic        hist_miss [3];
    logic [23:0] hist_px [3];

    function automatic logic f_de(input int mode, input int pos);
        return (mode == 2) && ((pos % c_h_tot) < c_h_act) && ((pos / c_h_tot) < c_v_act);
    endfunction
    function automatic logic f_hs(input int mode, input int pos);
        return (mode == 2) && ((pos % c_h_tot) >= 5) && ((pos % c_h_tot) < 7);
    endfunction
    function automatic logic f_vs(input int mode, input int pos);
        return (mode == 2) && ((pos / c_h_tot) == 3);
    endfunction

    logic        exp_de0, exp_avail, exp_rd, exp_fs;
    logic [23:0] exp_px0;
    assign exp_de0   = f_de(m_mode, m_pos);
    assign exp_avail = (wr_ptr != rd_ptr);
    assign exp_rd    = exp_de0 && exp_avail;
    assign exp_fs    = (m_mode == 2) && (m_pos == 0);
    assign exp_px0   = !exp_de0 ? 24'h0 : (exp_avail ? mem[rd_ptr % 256] : c_fill);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_pos  <= 0;
            m_uf   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                hist_de[i] <= 1'b0; hist_hs[i] <= 1'b0; hist_vs[i] <= 1'b0;
                hist_miss[i] <= 1'b0; hist_px[i] <= '0;
            end
        end else begin
            hist_de[0]   <= exp_de0;             hist_de[1]   <= hist_de[0];   hist_de[2]   <= hist_de[1];
            hist_hs[0]   <= f_hs(m_mode, m_pos); hist_hs[1]   <= hist_hs[0];   hist_hs[2]   <= hist_hs[1];
            hist_vs[0]   <= f_vs(m_mode, m_pos); hist_vs[1]   <= hist_vs[0];   hist_vs[2]   <= hist_vs[1];
            hist_miss[0] <= exp_de0 && !exp_avail; hist_miss[1] <= hist_miss[0]; hist_miss[2] <= hist_miss[1];
            hist_px[0]   <= exp_px0;             hist_px[1]   <= hist_px[0];   hist_px[2]   <= hist_px[1];
            m_uf <= (hist_de[1] && hist_miss[1]) || (m_uf && !underflow_clr);
            case (m_mode)
                0: if (en) m_mode <= 1;
                1: begin
                    if (!en) m_mode <= 0;
                    else if (exp_avail) begin m_mode <= 2; m_pos <= 0; end
                end
                default: begin
                    if (m_pos == c_frame - 1) begin
                        m_pos <= 0;
                        if (!en) m_mode <= 0;
                    end else begin
                        m_pos <= m_pos + 1;
                    end
                end
            endcase
        end
    end

    int fs_cnt = 0, de_cnt = 0, hs_cnt = 0, vs_cnt = 0, rd_cnt = 0, rd_empty_cnt = 0, fill_cnt = 0;

    always @(negedge clk) begin
        check_val("vid_de",      32'(vid_de),        32'(hist_de[2]));
        check_val("vid_hs",      32'(vid_hs),        32'(hist_hs[2]));
        check_val("vid_vs",      32'(vid_vs),        32'(hist_vs[2]));
        check_val("vid_data",    32'(vid_data),      32'(hist_px[2]));
        check_val("frame_start", 32'(frame_start),   32'(exp_fs));
        check_val("fifo_rd_en",  32'(fifo_rd_en),    32'(exp_rd));
        check_val("underflow",   32'(underflow),     32'(m_uf));
        check_val("n_vid_hs",    32'(n_vid_hs),      32'(!hist_hs[2]));
        check_val("n_vid_vs",    32'(n_vid_vs),      32'(!hist_vs[2]));
        check_val("n_vid_de",    32'(n_vid_de),      32'(hist_de[2]));
        check_val("n_vid_data",  32'(n_vid_data),    32'(hist_px[2]));
        check_val("n_rd_en",     32'(n_fifo_rd_en),  32'(exp_rd));
        check_val("n_fs",        32'(n_frame_start), 32'(exp_fs));
        check_val("n_uf",        32'(n_underflow),   32'(m_uf));
        fs_cnt       <= fs_cnt + (frame_start ? 1 : 0);
        de_cnt       <= de_cnt + (vid_de ? 1 : 0);
        hs_cnt       <= hs_cnt + (vid_hs ? 1 : 0);
        vs_cnt       <= vs_cnt + (vid_vs ? 1 : 0);
        rd_cnt       <= rd_cnt + (fifo_rd_en ? 1 : 0);
        rd_empty_cnt <= rd_empty_cnt + ((fifo_rd_en && fifo_rd_empty) ? 1 : 0);
        fill_cnt     <= fill_cnt + ((vid_de && vid_data == c_fill) ? 1 : 0);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [23:0] v);
        wr_val = v;
        wr_req = 1'b1;
        step();
        wr_req = 1'b0;
    endtask

    task automatic wait_fs(input string tag);
        int k;
        k = 0;
        while (frame_start !== 1'b1 && k < 200) begin
            step();
            k++;
        end
        check_val(tag, 32'(frame_start), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (m_mode != 0 && k < 200) begin
            step();
            k++;
        end
        check_val(tag, 32'(k < 200), 32'd1);
        step(5);
    endtask

    task automatic clear_uf();
        underflow_clr = 1'b1;
        step();
        underflow_clr = 1'b0;
    endtask

    initial begin
        int b_fs, b_de, b_hs, b_vs, b_rd, b_re, b_fill, k, lat, npx, hold;

        step(3);
        check_val("rst_de",   32'(vid_de),     32'd0);
        check_val("rst_hs",   32'(vid_hs),     32'd0);
        check_val("rst_n_hs", 32'(n_vid_hs),   32'd1);
        check_val("rst_rd",   32'(fifo_rd_en), 32'd0);
        check_val("rst_uf",   32'(underflow),  32'd0);
        rst_n = 1'b1;
        step(2);

        // Full frame from pixels 1..8
        b_fs = fs_cnt; b_de = de_cnt; b_hs = hs_cnt; b_vs = vs_cnt;
        for (int i = 1; i <= 8; i++) push(24'(i));
        en = 1'b1;
        k = 0;
        while (!fifo_rd_en && k < 50) begin step(); k++; end
        check_val("A_fs_first_rd", 32'(frame_start), 32'd1);
        lat = 0;
        while (!vid_de && lat < 20) begin step(); lat++; end
        check_val("A_rd_to_de", 32'(lat), 32'd3);
        step(5);
        en = 1'b0;
        wait_idle("A_idle");
        step(10);
        check_val("A_fs_cnt", 32'(fs_cnt - b_fs), 32'd1);
        check_val("A_de_cnt", 32'(de_cnt - b_de), 32'd8);
        check_val("A_hs_cnt", 32'(hs_cnt - b_hs), 32'd10);
        check_val("A_vs_cnt", 32'(vs_cnt - b_vs), 32'd8);

        // en dropped at line 0 pixel 2: the frame still runs to the end
        b_fs = fs_cnt; b_de = de_cnt;
        for (int i = 0; i < 8; i++) push(24'($urandom()));
        en = 1'b1;
        wait_fs("B_fs");
        step(2);
        en = 1'b0;
        step(38);
        check_val("B_last_hs", 32'(vid_hs), 32'd1);
        step(60);
        check_val("B_fs_cnt", 32'(fs_cnt - b_fs), 32'd1);
        check_val("B_de_cnt", 32'(de_cnt - b_de), 32'd8);

        // Underflow after pixel 6
        b_de = de_cnt; b_re = rd_empty_cnt; b_fill = fill_cnt;
        for (int i = 1; i <= 6; i++) push(24'(i));
        en = 1'b1;
        wait_fs("C_fs");
        step(3);
        en = 1'b0;
        wait_idle("C_idle");
        check_val("C_uf_set",   32'(underflow), 32'd1);
        check_val("C_de_cnt",   32'(de_cnt - b_de), 32'd8);
        check_val("C_fill_cnt", 32'(fill_cnt - b_fill), 32'd2);
        check_val("C_rd_empty", 32'(rd_empty_cnt - b_re), 32'd0);
        clear_uf();
        check_val("C_uf_clr",   32'(underflow), 32'd0);

        // Enabled with an empty FIFO: hold in WAIT_DATA until the first write
        b_fs = fs_cnt; b_rd = rd_cnt;
        en = 1'b1;
        step(10);
        check_val("D_no_fs", 32'(fs_cnt - b_fs), 32'd0);
        check_val("D_no_rd", 32'(rd_cnt - b_rd), 32'd0);
        push(24'h123456);
        check_val("D_fs_wait", 32'(frame_start), 32'd0);
        step();
        check_val("D_fs_next", 32'(frame_start), 32'd1);
        en = 1'b0;
        wait_idle("D_idle");
        clear_uf();

        // Asynchronous reset at line 1 pixel 1
        for (int i = 0; i < 8; i++) push(24'($urandom()));
        en = 1'b1;
        wait_fs("E_fs");
        step(9);
        rst_n = 1'b0;
        #1;
        check_val("E_rst_de",   32'(vid_de),      32'd0);
        check_val("E_rst_hs",   32'(vid_hs),      32'd0);
        check_val("E_rst_vs",   32'(vid_vs),      32'd0);
        check_val("E_rst_rd",   32'(fifo_rd_en),  32'd0);
        check_val("E_rst_fs",   32'(frame_start), 32'd0);
        check_val("E_rst_nvs",  32'(n_vid_vs),    32'd1);
        step(2);
        rst_n = 1'b1;
        wait_fs("E_refs");
        en = 1'b0;
        wait_idle("E_idle");
        clear_uf();

        // Randomised frames with en toggling and random clear pulses
        for (int it = 0; it < 6; it++) begin
            npx  = $urandom_range(12, 2);
            hold = $urandom_range(70, 1);
            for (int j = 0; j < npx; j++) push(24'($urandom()));
            en = 1'b1;
            wait_fs("F_fs");
            for (int j = 0; j < hold; j++) begin
                en            = ($urandom_range(3, 0) != 0);
                underflow_clr = ($urandom_range(7, 0) == 0);
                step();
            end
            underflow_clr = 1'b0;
            en = 1'b0;
            wait_idle("F_idle");
        end

        step(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
